// File: rtl/mvm_uart_rx_loader_if.sv
// Frame hand-off bundle between the UART receive loader (master) and the MVM core (slave).
// Carries the K matrix, the X vector and a valid/ready pair.
interface mvm_uart_rx_loader_if #(
  parameter int R   = 2,
  parameter int C   = 2,
  parameter int W_K = 4,
  parameter int W_X = 4
);
  logic [R*C*W_K-1:0] m_k;
  logic [C*W_X-1:0]   m_x;
  logic               m_valid;
  logic               m_ready;

  modport master (output m_k, output m_x, output m_valid, input  m_ready);
  modport slave  (input  m_k, input  m_x, input  m_valid, output m_ready);
endinterface

// File: rtl/mvm_uart_rx_loader.sv
// 8N1 UART receiver that assembles an R x C matrix K plus a C-element vector X
// and hands each completed frame to the MVM core through a one-deep holding register.
module mvm_uart_rx_loader #(
  parameter int CLOCKS_PER_PULSE = 434,
  parameter int R                = 2,
  parameter int C                = 2,
  parameter int W_K              = 4,
  parameter int W_X              = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  mvm_uart_rx_loader_if.master  m,
  output logic                  frame_err,
  output logic                  overflow
);

  localparam int KN = R * C;
  localparam int NB = KN + C;
  localparam int TW = $clog2(CLOCKS_PER_PULSE);
  localparam int CW = $clog2(NB);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          sync_q;
  logic                rxs;
  logic [TW-1:0]       timer_q, timer_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                byte_ok, byte_bad, timer_zero;
  logic [CW-1:0]       byte_cnt_q;
  logic [KN*W_K-1:0]   k_asm_q, k_q;
  logic [C*W_X-1:0]    x_asm_q, x_q;
  logic                frame_done_q, valid_q, frame_err_q, overflow_q;

  // Idle-high line: synchronizer flops come out of reset at 1 so no false start edge is seen.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end
  assign rxs        = sync_q[1];
  assign timer_zero = (timer_q == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!rxs) state_d = START;
      START: if (timer_zero) state_d = rxs ? IDLE : DATA;
      DATA:  if (timer_zero && bit_idx_q == 3'd7) state_d = STOP;
      STOP:  if (timer_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    timer_d   = timer_zero ? timer_q : timer_q - TW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_ok   = 1'b0;
    byte_bad  = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d   = HALF_LOAD;
        bit_idx_d = 3'd0;
      end
      START: if (timer_zero) timer_d = FULL_LOAD;
      DATA: if (timer_zero) begin
        shift_d   = {rxs, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        timer_d   = FULL_LOAD;
      end
      STOP: if (timer_zero) begin
        byte_ok  = rxs;
        byte_bad = !rxs;
      end
      default: ;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q   <= '0;
      k_asm_q      <= '0;
      x_asm_q      <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_err_q  <= byte_bad;
      frame_done_q <= byte_ok && (byte_cnt_q == LAST_BYTE);
      if (byte_ok) byte_cnt_q <= (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + CW'(1);
      for (int i = 0; i < KN; i++)
        if (byte_ok && byte_cnt_q == CW'(i)) k_asm_q[i*W_K +: W_K] <= shift_q[W_K-1:0];
      for (int j = 0; j < C; j++)
        if (byte_ok && byte_cnt_q == CW'(KN + j)) x_asm_q[j*W_X +: W_X] <= shift_q[W_X-1:0];
    end
  end

  // A frame completing while the core drains the old one on the same edge reloads without overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '0;
      x_q        <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (frame_done_q && (!valid_q || m.m_ready)) begin
        k_q     <= k_asm_q;
        x_q     <= x_asm_q;
        valid_q <= 1'b1;
      end else begin
        if (frame_done_q)           overflow_q <= 1'b1;
        if (valid_q && m.m_ready)   valid_q    <= 1'b0;
      end
    end
  end

  assign m.m_k     = k_q;
  assign m.m_x     = x_q;
  assign m.m_valid = valid_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mvm_uart_rx_loader.sv
// Directed bench for mvm_uart_rx_loader at 8 clocks per bit, 2x2 matrix, 4-bit elements.
module tb_mvm_uart_rx_loader;

  localparam int CPP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic frame_err, overflow;
  int   errors = 0;
  int   checks = 0;
  int   ferr_cnt = 0;
  int   ovf_cnt  = 0;
  int   ferr_base, ovf_base;

  mvm_uart_rx_loader_if #(.R(2), .C(2), .W_K(4), .W_X(4)) m_if ();

  mvm_uart_rx_loader #(
    .CLOCKS_PER_PULSE(CPP), .R(2), .C(2), .W_K(4), .W_X(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .m        (m_if),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overflow)  ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (CPP) @(negedge clk);
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Bytes listed first-sent in the most significant position.
  task automatic send_frame(input logic [47:0] f);
    for (int i = 0; i < 6; i++) send_byte(f[47-8*i -: 8], 1'b1);
  endtask

  task automatic accept();
    m_if.m_ready = 1'b1;
    @(negedge clk);
    m_if.m_ready = 1'b0;
  endtask

  initial begin
    m_if.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_m_k",       32'(m_if.m_k),     32'h0);
    check("reset_m_x",       32'(m_if.m_x),     32'h0);
    check("reset_m_valid",   32'(m_if.m_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err),    32'h0);
    check("reset_overflow",  32'(overflow),     32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame, held until accepted.
    send_frame(48'h01_02_03_04_05_06);
    check("single_valid", 32'(m_if.m_valid), 32'h1);
    check("single_m_k",   32'(m_if.m_k),     32'h4321);
    check("single_m_x",   32'(m_if.m_x),     32'h65);
    repeat (10) @(negedge clk);
    check("single_hold_valid", 32'(m_if.m_valid), 32'h1);
    check("single_hold_m_k",   32'(m_if.m_k),     32'h4321);
    accept();
    check("single_drop_valid", 32'(m_if.m_valid), 32'h0);

    // Upper nibbles are ignored.
    send_frame(48'hFA_1B_2C_3D_4E_5F);
    check("nibble_valid", 32'(m_if.m_valid), 32'h1);
    check("nibble_m_k",   32'(m_if.m_k),     32'hDCBA);
    check("nibble_m_x",   32'(m_if.m_x),     32'hFE);
    accept();

    // Framing error on the fourth byte.
    ferr_base = ferr_cnt;
    ovf_base  = ovf_cnt;
    send_byte(8'h19, 1'b1);
    send_byte(8'h28, 1'b1);
    send_byte(8'h37, 1'b1);
    send_byte(8'hA5, 1'b0);
    repeat (12) @(negedge clk);
    check("ferr_pulse_count", 32'(ferr_cnt - ferr_base), 32'd1);
    check("ferr_no_valid_yet", 32'(m_if.m_valid), 32'h0);
    send_byte(8'h46, 1'b1);
    send_byte(8'h5C, 1'b1);
    send_byte(8'h6E, 1'b1);
    check("ferr_valid", 32'(m_if.m_valid), 32'h1);
    check("ferr_m_k",   32'(m_if.m_k),     32'h6789);
    check("ferr_m_x",   32'(m_if.m_x),     32'hEC);
    check("ferr_total", 32'(ferr_cnt - ferr_base), 32'd1);
    check("ferr_no_ovf", 32'(ovf_cnt - ovf_base),  32'd0);
    accept();

    // Overflow: second frame arrives while the first is still held.
    ovf_base = ovf_cnt;
    send_frame(48'h01_03_05_07_09_0B);
    check("ovf_first_m_k", 32'(m_if.m_k), 32'h7531);
    check("ovf_none_yet",  32'(ovf_cnt - ovf_base), 32'd0);
    send_frame(48'h0F_0E_0D_0C_0B_0A);
    check("ovf_pulse_count", 32'(ovf_cnt - ovf_base), 32'd1);
    check("ovf_valid",       32'(m_if.m_valid), 32'h1);
    check("ovf_keep_m_k",    32'(m_if.m_k),     32'h7531);
    check("ovf_keep_m_x",    32'(m_if.m_x),     32'hB9);
    accept();

    // Two-cycle start glitch must be rejected.
    ferr_base = ferr_cnt;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    send_frame(48'h0C_0D_0E_0F_01_02);
    check("glitch_valid", 32'(m_if.m_valid), 32'h1);
    check("glitch_m_k",   32'(m_if.m_k),     32'hFEDC);
    check("glitch_m_x",   32'(m_if.m_x),     32'h21);
    check("glitch_no_ferr", 32'(ferr_cnt - ferr_base), 32'd0);
    accept();

    // Mid-frame reset discards the partial frame and clears the outputs.
    send_byte(8'h03, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h03, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_m_k",     32'(m_if.m_k),     32'h0);
    check("rst_mid_m_x",     32'(m_if.m_x),     32'h0);
    check("rst_mid_m_valid", 32'(m_if.m_valid), 32'h0);
    check("rst_mid_ferr",    32'(frame_err),    32'h0);
    check("rst_mid_ovf",     32'(overflow),     32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(48'h08_07_06_05_04_03);
    check("post_rst_valid", 32'(m_if.m_valid), 32'h1);
    check("post_rst_m_k",   32'(m_if.m_k),     32'h5678);
    check("post_rst_m_x",   32'(m_if.m_x),     32'h34);
    accept();
    check("post_rst_drop",  32'(m_if.m_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
